// File: rtl/mux_rr_arbiter_if.sv
// Handshake and select bundle between the result-mux arbiter and its requesters/consumer.
// The arbiter takes the master side; requesters and the consumer take the slave side.
interface mux_rr_arbiter_if;
  logic [15:0] req;
  logic        out_ready;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        out_valid;
  logic        busy;

  modport master (
    input  req,
    input  out_ready,
    output sel,
    output grant,
    output out_valid,
    output busy
  );

  modport slave (
    output req,
    output out_ready,
    input  sel,
    input  grant,
    input  out_valid,
    input  busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 16:1 result-mux select, holding each grant through valid/ready.
// Define ARB_BURST_EN to let a still-requesting winner keep the grant for up to BURST_MAX transfers.
//
// state | meaning
// IDLE  | no grant; outputs zero; arbitrating from ptr
// BUSY  | grant/sel presented with out_valid, frozen until out_ready
module mux_rr_arbiter #(
  parameter int BURST_MAX = 4
) (
  input logic             clk,
  input logic             rst_n,
  mux_rr_arbiter_if.master bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] grant_q, grant_d;
  logic [3:0]  base;
  logic [3:0]  idx;
  logic [3:0]  win;
  logic        found;
  logic        rotate;

  if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_burst_range
    $error("mux_rr_arbiter: BURST_MAX must be in 1..15");
  end

`ifdef ARB_BURST_EN
  logic [3:0] cnt_q, cnt_d;
  logic       keep;
`endif

  // In BUSY the search base is the post-handshake pointer, so the just-served source ranks last.
  always_comb begin
    base  = (state_q == BUSY) ? sel_q + 4'd1 : ptr_q;
    found = 1'b0;
    win   = 4'd0;
    idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = base + 4'(i);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef ARB_BURST_EN
  always_comb begin
    keep   = bus.req[sel_q] && (cnt_q < 4'(BURST_MAX - 1));
    rotate = !keep;
  end
`else
  always_comb begin
    rotate = 1'b1;
  end
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
`ifdef ARB_BURST_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          sel_d   = win;
          grant_d = 16'd1 << win;
`ifdef ARB_BURST_EN
          cnt_d   = 4'd0;
`endif
        end
      end
      BUSY: begin
        if (bus.out_ready) begin
          if (rotate) begin
            ptr_d = sel_q + 4'd1;
`ifdef ARB_BURST_EN
            cnt_d = 4'd0;
`endif
            if (found) begin
              sel_d   = win;
              grant_d = 16'd1 << win;
            end else begin
              state_d = IDLE;
              sel_d   = 4'd0;
              grant_d = 16'd0;
            end
          end
`ifdef ARB_BURST_EN
          else begin
            cnt_d = cnt_q + 4'd1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 4'd0;
        grant_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 4'd0;
      sel_q   <= 4'd0;
      grant_q <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

`ifdef ARB_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.out_valid = (state_q == BUSY);
  assign bus.busy      = (state_q == BUSY);

endmodule
